// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: next-PC select encodings, fetch FSM states and default reset PC.
package ifu_fetch_pkg;
  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_HOLD = 2'd1, S_ERR = 2'd2} state_t;
endpackage

// File: rtl/ifu_fetch_npc_calc.sv
// npc_calc: combinational next-PC selection from the resolved NPC op.
module npc_calc
  import ifu_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] ra_val,
  output logic [31:0] npc
);
  logic [31:0] seq;
  always_comb begin
    seq = pc + 32'd4;
    npc = npc_op == NPC_PC4 ? seq :
          npc_op == NPC_BR  ? seq + {{14{imm16[15]}}, imm16, 2'b00} :
          npc_op == NPC_J   ? {pc[31:28], imm26, 2'b00} : ra_val;
  end
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC register, req/ack fetch FSM and instruction latch for decode.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  npc_op,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] ra_val,
  input  logic        advance,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        im_ack,
  output logic        fetch_err
);
  state_t state, state_nx;
  logic [31:0] npc;
  logic commit;
  npc_calc u_npc (
    .pc(pc),
    .npc_op(npc_op),
    .imm16(imm16),
    .imm26(imm26),
    .ra_val(ra_val),
    .npc(npc)
  );
  always_ff @(posedge clk)
    state <= reset ? S_FETCH : state_nx;
  always_comb begin
    commit = state == S_HOLD && advance;
    state_nx = state == S_FETCH && im_ack ? S_HOLD :
               commit ? (npc[1:0] == 2'b00 ? S_FETCH : S_ERR) : state;
    im_req = state == S_FETCH;
    instr_valid = state == S_HOLD;
    fetch_err = state == S_ERR;
    im_addr = pc;
    pc4 = pc + 32'd4;
  end
  // a misaligned target leaves pc at the trapping instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      instr <= '0;
    end else begin
      if (state == S_FETCH && im_ack) instr <= im_rdata;
      if (commit && npc[1:0] == 2'b00) pc <= npc;
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed scenarios for the fetch unit with hand-computed expectations.
module tb_ifu_fetch;
  logic clk, reset, advance, instr_valid, im_req, im_ack, fetch_err;
  logic [1:0] npc_op;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] ra_val, instr, pc, pc4, im_addr, im_rdata;
  int vecs, errs;

  ifu_fetch dut (
    .clk(clk), .reset(reset), .npc_op(npc_op), .imm16(imm16), .imm26(imm26),
    .ra_val(ra_val), .advance(advance), .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc4(pc4), .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata),
    .im_ack(im_ack), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; advance = 1'b0; im_ack = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // from S_HOLD: commit a jr to addr and complete its fetch with an immediate ack
  task automatic goto(input logic [31:0] addr, input logic [31:0] word);
    npc_op = 2'b11; ra_val = addr; advance = 1'b1; im_ack = 1'b1; im_rdata = word;
    step();
    advance = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    im_ack = 1'b1; im_rdata = 32'h1111_2222;
    vecs++; if (im_req !== 1'b1) begin errs++; $display("FAIL reset_im_req got %b want 1", im_req); end
    vecs++; if (im_addr !== 32'h3000) begin errs++; $display("FAIL reset_im_addr got %h want 00003000", im_addr); end
    vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    vecs++; if (instr !== 32'h0) begin errs++; $display("FAIL reset_instr got %h want 00000000", instr); end
    step();
    vecs++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL first_valid got %b want 1", instr_valid); end
    vecs++; if (pc !== 32'h3000) begin errs++; $display("FAIL first_pc got %h want 00003000", pc); end
    vecs++; if (pc4 !== 32'h3004) begin errs++; $display("FAIL first_pc4 got %h want 00003004", pc4); end
    vecs++; if (fetch_err !== 1'b0) begin errs++; $display("FAIL first_err got %b want 0", fetch_err); end
    vecs++; if (instr !== 32'h1111_2222) begin errs++; $display("FAIL first_instr got %h want 11112222", instr); end
    vecs++; if (im_req !== 1'b0) begin errs++; $display("FAIL hold_im_req got %b want 0", im_req); end
  endtask

  task automatic test_wait();
    do_reset();
    im_ack = 1'b0; advance = 1'b1; npc_op = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL wait_valid[%0d] got %b want 0", i, instr_valid); end
      vecs++; if (im_req !== 1'b1 || pc !== 32'h3000) begin errs++; $display("FAIL wait_req_pc[%0d] got %b/%h want 1/00003000", i, im_req, pc); end
    end
    advance = 1'b0; im_ack = 1'b1; im_rdata = 32'h3C01_1234;
    step();
    vecs++; if (instr_valid !== 1'b1 || instr !== 32'h3C01_1234) begin errs++; $display("FAIL wait_instr got %b/%h want 1/3c011234", instr_valid, instr); end
    vecs++; if (pc !== 32'h3000) begin errs++; $display("FAIL wait_pc got %h want 00003000", pc); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    npc_op = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      exp = 32'h3000 + 32'(4 * i);
      advance = 1'b1; im_ack = 1'b1; im_rdata = 32'hA000_0000 + 32'(i);
      step();
      vecs++; if (pc !== exp || instr_valid !== 1'b0) begin errs++; $display("FAIL seq_pc[%0d] got %h/%b want %h/0", i, pc, instr_valid, exp); end
      im_ack = 1'b0;
      step();
      vecs++; if (pc !== exp || im_req !== 1'b1) begin errs++; $display("FAIL seq_ignore[%0d] got %h/%b want %h/1", i, pc, im_req, exp); end
      advance = 1'b0; im_ack = 1'b1;
      step();
      vecs++; if (instr !== 32'hA000_0000 + 32'(i) || instr_valid !== 1'b1) begin errs++; $display("FAIL seq_instr[%0d] got %h/%b want %h/1", i, instr, instr_valid, 32'hA000_0000 + 32'(i)); end
    end
  endtask

  task automatic test_control();
    goto(32'h3008, 32'h1);
    npc_op = 2'b01; imm16 = 16'hFFFF; advance = 1'b1;
    step();
    advance = 1'b0;
    vecs++; if (pc !== 32'h3008 || instr_valid !== 1'b0) begin errs++; $display("FAIL br_back got %h/%b want 00003008/0", pc, instr_valid); end
    step();
    goto(32'h3000, 32'h2);
    vecs++; if (pc4 !== 32'h3004) begin errs++; $display("FAIL j_pc4 got %h want 00003004", pc4); end
    npc_op = 2'b10; imm26 = 26'h000_0C05; advance = 1'b1;
    step();
    advance = 1'b0;
    vecs++; if (pc !== 32'h3014) begin errs++; $display("FAIL j_pc got %h want 00003014", pc); end
    step();
    goto(32'h3020, 32'h3);
    vecs++; if (pc !== 32'h3020 || instr_valid !== 1'b1) begin errs++; $display("FAIL jr_pc got %h/%b want 00003020/1", pc, instr_valid); end
    npc_op = 2'b01; imm16 = 16'h0003; advance = 1'b1;
    step();
    advance = 1'b0;
    vecs++; if (pc !== 32'h3030) begin errs++; $display("FAIL br_fwd got %h want 00003030", pc); end
    step();
    goto(32'h9000_0010, 32'h4);
    npc_op = 2'b10; imm26 = 26'h000_0001; advance = 1'b1;
    step();
    advance = 1'b0;
    vecs++; if (pc !== 32'h9000_0004) begin errs++; $display("FAIL j_region got %h want 90000004", pc); end
    step();
  endtask

  task automatic test_misaligned();
    goto(32'h3030, 32'h5);
    npc_op = 2'b11; ra_val = 32'h3002; advance = 1'b1;
    step();
    vecs++; if (fetch_err !== 1'b1 || pc !== 32'h3030) begin errs++; $display("FAIL mis_err got %b/%h want 1/00003030", fetch_err, pc); end
    vecs++; if (im_req !== 1'b0 || instr_valid !== 1'b0) begin errs++; $display("FAIL mis_outs got %b/%b want 0/0", im_req, instr_valid); end
    npc_op = 2'b00; im_ack = 1'b1; im_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++; if (fetch_err !== 1'b1 || pc !== 32'h3030 || instr !== 32'h5 || im_req !== 1'b0) begin errs++; $display("FAIL mis_sticky[%0d] got %b/%h/%h want 1/00003030/00000005", i, fetch_err, pc, instr); end
    end
    do_reset();
    vecs++; if (pc !== 32'h3000 || fetch_err !== 1'b0 || im_req !== 1'b1) begin errs++; $display("FAIL mis_reset got %h/%b/%b want 00003000/0/1", pc, fetch_err, im_req); end
    im_ack = 1'b1; im_rdata = 32'h6;
    step();
  endtask

  task automatic test_wrap_and_reset();
    goto(32'hFFFF_FFFC, 32'h7);
    vecs++; if (pc4 !== 32'h0) begin errs++; $display("FAIL wrap_pc4 got %h want 00000000", pc4); end
    npc_op = 2'b00; advance = 1'b1;
    step();
    advance = 1'b0;
    vecs++; if (pc !== 32'h0) begin errs++; $display("FAIL wrap_pc got %h want 00000000", pc); end
    step();
    npc_op = 2'b01; imm16 = 16'h8000; advance = 1'b1;
    step();
    advance = 1'b0;
    vecs++; if (pc !== 32'hFFFE_0004) begin errs++; $display("FAIL wrap_br got %h want fffe0004", pc); end
    im_ack = 1'b1; im_rdata = 32'hDEAD_BEEF; reset = 1'b1;
    step();
    reset = 1'b0; im_ack = 1'b0;
    vecs++; if (instr !== 32'h0 || pc !== 32'h3000 || instr_valid !== 1'b0) begin errs++; $display("FAIL midfetch_reset got %h/%h/%b want 00000000/00003000/0", instr, pc, instr_valid); end
  endtask

  initial begin
    vecs = 0; errs = 0;
    reset = 1'b1; advance = 1'b0; im_ack = 1'b0; im_rdata = '0;
    npc_op = 2'b00; imm16 = '0; imm26 = '0; ra_val = '0;
    test_reset();
    test_wait();
    test_sequential();
    test_control();
    test_misaligned();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
